// File: rtl/sc_fifo.sv
// Single-clock FIFO with integrated storage, fill count and thresholds.
// Define SC_FIFO_ERR_FLAGS_EN to build the sticky ovf_o/udf_o logic.
module sc_fifo #(
  parameter int    DWIDTH             = 8,
  parameter int    AWIDTH             = 3,
  parameter string SHOWAHEAD          = "OFF",
  parameter int    ALMOST_FULL_VALUE  = 2**AWIDTH-1,
  parameter int    ALMOST_EMPTY_VALUE = 1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_empty_o,
  output logic              almost_full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              ovf_o,
  output logic              udf_o
);

  localparam int DEPTH = 2**AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_C =
    (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_C =
    (AWIDTH+1)'(ALMOST_FULL_VALUE);
  localparam logic [AWIDTH:0] AE_C =
    (AWIDTH+1)'(ALMOST_EMPTY_VALUE);
  localparam logic [AWIDTH:0]   CNT_ONE = 1;
  localparam logic [AWIDTH-1:0] PTR_ONE = 1;

  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   cnt_q, cnt_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ae_q, ae_d;
  logic              af_q, af_d;
  logic              wr_acc, rd_acc;

  // Acceptance uses the registered flags only.
  assign wr_acc = wrreq_i & ~full_q;
  assign rd_acc = rdreq_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == DEPTH_C);
    ae_d    = (cnt_d < AE_C);
    af_d    = (cnt_d >= AF_C);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
    end
  end

  // Storage is never cleared; a write in a reset cycle is dropped.
  always_ff @(posedge clk_i) begin
    if (wr_acc && !srst_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign usedw_o        = cnt_q;
  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign almost_empty_o = ae_q;
  assign almost_full_o  = af_q;

  generate
    if (SHOWAHEAD == "ON") begin : g_show
      assign q_o = mem_q[rd_ptr_q];
    end else begin : g_norm
      logic [DWIDTH-1:0] q_q, q_d;
      always_comb begin
        q_d = q_q;
        if (rd_acc) q_d = mem_q[rd_ptr_q];
      end
      always_ff @(posedge clk_i) begin
        if (srst_i) q_q <= '0;
        else        q_q <= q_d;
      end
      assign q_o = q_q;
    end
  endgenerate

`ifdef SC_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // A rejected request paired with an accepted opposite one is benign.
  always_comb begin
    ovf_d = ovf_q | (wrreq_i & full_q & ~rdreq_i);
    udf_d = udf_q | (rdreq_i & empty_q & ~wrreq_i);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`else
  assign ovf_o = 1'b0;
  assign udf_o = 1'b0;
`endif

endmodule

// File: tb/tb_sc_fifo.sv
// Directed bench for sc_fifo: table-driven normal mode
// plus hand sequences for showahead mode.
module tb_sc_fifo;

`ifdef SC_FIFO_ERR_FLAGS_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  typedef struct {
    logic       srst;
    logic       wr;
    logic       rd;
    logic [7:0] d;
    logic [7:0] q;
    logic [3:0] u;
    logic       ovf;
    logic       udf;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       srst_n, wr_n, rd_n;
  logic [7:0] d_n, q_n;
  logic       e_n, f_n, ae_n, af_n, ovf_n, udf_n;
  logic [3:0] u_n;

  logic       srst_s, wr_s, rd_s;
  logic [7:0] d_s, q_s;
  logic       e_s, f_s, ae_s, af_s, ovf_s, udf_s;
  logic [3:0] u_s;

  sc_fifo #(.DWIDTH(8), .AWIDTH(3), .SHOWAHEAD("OFF")) u_norm (
    .clk_i(clk), .srst_i(srst_n), .data_i(d_n),
    .wrreq_i(wr_n), .rdreq_i(rd_n), .q_o(q_n),
    .empty_o(e_n), .full_o(f_n),
    .almost_empty_o(ae_n), .almost_full_o(af_n),
    .usedw_o(u_n), .ovf_o(ovf_n), .udf_o(udf_n)
  );

  sc_fifo #(.DWIDTH(8), .AWIDTH(3), .SHOWAHEAD("ON")) u_show (
    .clk_i(clk), .srst_i(srst_s), .data_i(d_s),
    .wrreq_i(wr_s), .rdreq_i(rd_s), .q_o(q_s),
    .empty_o(e_s), .full_o(f_s),
    .almost_empty_o(ae_s), .almost_full_o(af_s),
    .usedw_o(u_s), .ovf_o(ovf_s), .udf_o(udf_s)
  );

  vec_t vq[$];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input logic s, w, r,
                     input logic [7:0] d, q,
                     input logic [3:0] u,
                     input logic o, un);
    vec_t v;
    v.srst = s; v.wr = w; v.rd = r; v.d = d;
    v.q = q; v.u = u; v.ovf = o; v.udf = un;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h want %0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic chk_norm(input int i, input vec_t v);
    chk("q", i, 32'(q_n), 32'(v.q));
    chk("usedw", i, 32'(u_n), 32'(v.u));
    chk("empty", i, 32'(e_n), 32'(v.u == 0));
    chk("full", i, 32'(f_n), 32'(v.u == 8));
    chk("aempty", i, 32'(ae_n), 32'(v.u < 1));
    chk("afull", i, 32'(af_n), 32'(v.u >= 7));
    chk("ovf", i, 32'(ovf_n), 32'(v.ovf));
    chk("udf", i, 32'(udf_n), 32'(v.udf));
  endtask

  task automatic step_s(input logic s, w, r,
                        input logic [7:0] d);
    srst_s = s; wr_s = w; rd_s = r; d_s = d;
    @(posedge clk);
    #1;
    n_vec++;
  endtask

  task automatic chk_show(input int i, input logic [3:0] u,
                          input logic [7:0] q);
    chk("s_usedw", i, 32'(u_s), 32'(u));
    chk("s_empty", i, 32'(e_s), 32'(u == 0));
    chk("s_full", i, 32'(f_s), 32'(u == 8));
    chk("s_aempty", i, 32'(ae_s), 32'(u < 1));
    chk("s_afull", i, 32'(af_s), 32'(u >= 7));
    chk("s_ovf", i, 32'(ovf_s), 32'(1'b0));
    chk("s_udf", i, 32'(udf_s), 32'(1'b0));
    if (u != 0) chk("s_q", i, 32'(q_s), 32'(q));
  endtask

  initial begin
    srst_n = 1'b1; wr_n = 1'b0; rd_n = 1'b0; d_n = '0;
    srst_s = 1'b1; wr_s = 1'b0; rd_s = 1'b0; d_s = '0;

    add(1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    for (int i = 1; i <= 8; i++)
      add(0, 1, 0, 8'(i), 8'h00, 4'(i), 0, 0);
    add(0, 1, 0, 8'hFF, 8'h00, 8, ERR, 0);
    for (int k = 1; k <= 8; k++)
      add(0, 0, 1, 8'h00, 8'(k), 4'(8 - k), ERR, 0);
    add(0, 0, 1, 8'h00, 8'h08, 0, ERR, ERR);
    add(1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 1, 0, 8'(8'h10 + i), 8'h00, 4'(i + 1), 0, 0);
    for (int i = 0; i < 20; i++)
      add(0, 1, 1, 8'(8'h14 + i), 8'(8'h10 + i), 4, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 1, 0, 8'(8'h28 + i), 8'h23, 4'(5 + i), 0, 0);
    add(0, 1, 1, 8'hEE, 8'h24, 7, 0, 0);
    for (int i = 0; i < 7; i++)
      add(0, 0, 1, 8'h00, 8'(8'h25 + i), 4'(6 - i), 0, 0);
    add(0, 1, 1, 8'h77, 8'h2B, 1, 0, 0);
    add(0, 0, 1, 8'h00, 8'h77, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 1, 0, 8'(8'h50 + i), 8'h77, 4'(i + 1), 0, 0);
    add(1, 1, 0, 8'h99, 8'h00, 0, 0, 0);
    add(0, 1, 0, 8'h60, 8'h00, 1, 0, 0);
    add(0, 0, 1, 8'h00, 8'h60, 0, 0, 0);

    foreach (vq[i]) begin
      srst_n = vq[i].srst;
      wr_n   = vq[i].wr;
      rd_n   = vq[i].rd;
      d_n    = vq[i].d;
      @(posedge clk);
      #1;
      n_vec++;
      chk_norm(i, vq[i]);
    end
    srst_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0;

    step_s(1, 0, 0, 8'h00); chk_show(100, 0, 8'h00);
    step_s(0, 1, 0, 8'hA5); chk_show(101, 1, 8'hA5);
    step_s(0, 0, 0, 8'h00); chk_show(102, 1, 8'hA5);
    step_s(0, 0, 1, 8'h00); chk_show(103, 0, 8'h00);
    step_s(0, 1, 0, 8'hB6); chk_show(104, 1, 8'hB6);
    step_s(0, 1, 0, 8'hC7); chk_show(105, 2, 8'hB6);
    step_s(0, 1, 1, 8'hD8); chk_show(106, 2, 8'hC7);
    step_s(0, 0, 1, 8'h00); chk_show(107, 1, 8'hD8);
    step_s(0, 0, 1, 8'h00); chk_show(108, 0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step_s(0, 1, 0, 8'(8'h30 + i));
      chk_show(110 + i, 4'(i + 1), 8'h30);
    end
    step_s(0, 1, 1, 8'hEE); chk_show(120, 7, 8'h31);
    step_s(0, 0, 0, 8'h00); chk_show(121, 7, 8'h31);
    step_s(1, 1, 0, 8'h99); chk_show(122, 0, 8'h00);
    step_s(0, 0, 0, 8'h00); chk_show(123, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
